// File: rtl/sum_diff_serial_alu.sv
// Bit-serial add/subtract unit: latches operands and mode on start, walks them LSB
// first through one full adder, then publishes result, carry/no-borrow and overflow.
module sum_diff_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A_D,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Handshake: start is a one-sided request with no ready; it is taken only in
  // S_IDLE (busy=0, done=0) and silently dropped in every other state.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-2:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic sum_bit;
  logic carry_nxt;
  logic last_bit;

  assign sum_bit   = op_a[0] ^ op_b[0] ^ carry;
  assign carry_nxt = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Subtract is a + ~b + 1: the +1 comes from seeding the carry with ~A_D.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= A_D ? b : ~b;
            carry <= ~A_D;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          carry  <= carry_nxt;
          cnt    <= cnt + CNT_W'(1);
          // Keep only the upper WIDTH-1 bits; the final bit joins on the last edge.
          res_sr <= (WIDTH-1)'({sum_bit, res_sr} >> 1);
          if (last_bit) begin
            result   <= {sum_bit, res_sr};
            cout     <= carry_nxt;
            overflow <= carry ^ carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_diff_serial_alu.sv
// Directed bench for sum_diff_serial_alu (WIDTH=8): hand-computed vectors, frozen
// inputs, mid-operation reset and back-to-back throughput.
module tb_sum_diff_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         A_D;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;

  // expected {cout, overflow, result} for queued back-to-back operations
  logic [W+1:0] exp_q[$];

  sum_diff_serial_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .A_D      (A_D),
    .start    (start),
    .a        (a),
    .b        (b),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Launch one operation, optionally disturb inputs during RUN, then check
  // latency, busy length and the completed outputs.
  task automatic do_op(input string tag, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                       input logic ad_i, input logic [W-1:0] exp_r, input logic exp_c,
                       input logic exp_v, input bit disturb);
    int n;
    int busy_cnt;
    @(negedge clk);
    a = a_i; b = b_i; A_D = ad_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (disturb) begin
        a     = W'($urandom_range(0, 255));
        b     = W'($urandom_range(0, 255));
        A_D   = ~A_D;
        start = (n == 3);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, W + 1);
    check({tag, "_busy_cycles"}, busy_cnt, W);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_cout"}, cout, exp_c);
    check({tag, "_overflow"}, overflow, exp_v);
  endtask

  // Watch a window of cycles and count done pulses / busy cycles.
  task automatic watch(input int cycles, output int dones, output int busies);
    dones = 0;
    busies = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dones;
    int busies;
    int n;
    int last_done;
    int seen;
    logic [W-1:0] bb_a[4]  = '{8'd25, 8'd20, 8'd100, 8'hFF};
    logic [W-1:0] bb_b[4]  = '{8'd17, 8'd10, 8'd100, 8'h01};
    logic         bb_ad[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] exp;

    reset = 1'b1; start = 1'b0; A_D = 1'b1; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    do_op("add_25_17", 8'd25, 8'd17, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_done_low", done, 0);
    check("hold_result", result, 8'h2A);
    do_op("sub_10_20", 8'd10, 8'd20, 1'b0, 8'hF6, 1'b0, 1'b0, 1'b0);
    do_op("sub_20_10", 8'd20, 8'd10, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b0);
    do_op("add_100_100", 8'd100, 8'd100, 1'b1, 8'hC8, 1'b0, 1'b1, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Reset on the 4th RUN cycle aborts the operation.
    @(negedge clk);
    a = 8'd50; b = 8'd60; A_D = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_cout", cout, 0);
    check("abort_overflow", overflow, 0);
    watch(12, dones, busies);
    check("abort_no_done", dones, 0);
    check("abort_no_busy", busies, 0);
    do_op("after_abort_add", 8'd3, 8'd4, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);

    // Frozen inputs: disturb everything during RUN, expect only 3+4.
    A_D = 1'b1;
    do_op("frozen_add_3_4", 8'd3, 8'd4, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1);
    watch(12, dones, busies);
    check("frozen_no_second_done", dones, 0);
    check("frozen_no_second_busy", busies, 0);

    // Back-to-back with start held high; operands advance on each done.
    exp_q.push_back({1'b0, 1'b0, 8'h2A});
    exp_q.push_back({1'b1, 1'b0, 8'h0A});
    exp_q.push_back({1'b0, 1'b1, 8'hC8});
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    @(negedge clk);
    a = bb_a[0]; b = bb_b[0]; A_D = bb_ad[0]; start = 1'b1;
    n = 0;
    seen = 0;
    last_done = 0;
    while (seen < 4 && n < 80) begin
      @(negedge clk);
      n++;
      if (done) begin
        exp = exp_q.pop_front();
        check($sformatf("b2b%0d_result", seen), result, exp[W-1:0]);
        check($sformatf("b2b%0d_cout", seen), cout, exp[W+1]);
        check($sformatf("b2b%0d_overflow", seen), overflow, exp[W]);
        if (seen == 0) check("b2b_first_latency", n, W + 1);
        else check($sformatf("b2b%0d_spacing", seen), n - last_done, W + 2);
        last_done = n;
        seen++;
        if (seen < 4) begin
          a = bb_a[seen]; b = bb_b[seen]; A_D = bb_ad[seen];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_all_done", seen, 4);
    check("busy_done_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_diff_serial_alu.md
# sum_diff_serial_alu

Bit-serial add/subtract datapath of the sum/difference design, sitting directly downstream of the add/subtract mode FSM and consuming its `A_D` mode bit (1 = add, 0 = subtract). On a start request it latches two operands and the mode, then produces `a + b` or `a - b` one bit per clock, LSB first. When finished it reports the registered result, carry/no-borrow and signed overflow with a one-cycle done pulse.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

- `clk`  input  1  rising-edge clock; single clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `A_D`  input  1  mode from the upstream mode FSM: 1 = add, 0 = subtract; sampled only when a start is accepted.
- `start`  input  1  request; accepted only in IDLE.
- `a`  input  WIDTH  operand A; sampled with `start`.
- `b`  input  WIDTH  operand B; sampled with `start`.
- `result`  output  WIDTH  registered sum/difference; held until the next completion.
- `cout`  output  1  final carry out. For add: unsigned carry. For subtract: 1 = no borrow (a >= b unsigned).
- `overflow`  output  1  two's-complement overflow of the completed operation.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse when `result`/`cout`/`overflow` update.

## Operation
- States: IDLE, RUN, DONE. Encoding is implementation choice.
- IDLE (`busy`=0, `done`=0):
  - On `start`=1, load shift registers with `a` and with `b` when `A_D`=1, or with `~b` when `A_D`=0.
  - Load the carry flop with `~A_D`, clear the bit counter, and go to RUN.
  - Otherwise stay in IDLE.
- RUN (`busy`=1):
  - Each edge computes sum = opA[0] ^ opB[0] ^ carry and carry = majority(opA[0], opB[0], carry).
  - Shifts the sum bit into the internal result shift register from the MSB side, shifts both operands right by one, and increments the counter.
  - On the edge processing bit WIDTH-1:
    - Load `result` from the completed shift register.
    - `cout` = final carry.
    - `overflow` = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - Go to DONE.
- DONE (`done`=1, `busy`=0): unconditional return to IDLE on the next edge.
- `start`, `a`, `b` and `A_D` are ignored in RUN and DONE. Mode and operands are frozen at acceptance, so upstream `A_D` may toggle mid-operation without effect.
- `result`, `cout` and `overflow` change only on the RUN→DONE edge; between completions they hold.
- Counter width is clog2(WIDTH)+1. No wrap-around occurs inside an operation.

## Timing
- Reset: state IDLE, `result`=0, `cout`=0, `overflow`=0, `busy`=0, `done`=0, internal registers cleared.
- Reset wins over every other condition. Reset asserted during RUN or DONE aborts the operation: no `done` pulse, outputs return to reset values after that edge.
- Let the start be sampled at edge E0:
  - `busy`=1 for exactly WIDTH cycles (after E0 through E(WIDTH-1)).
  - `done`=1 for the single cycle after E(WIDTH), and outputs are valid from that same cycle.
  - The block is back in IDLE after E(WIDTH+1).
  - The earliest next start is sampled at E(WIDTH+2).
- Throughput with `start` held high: one operation per WIDTH+2 cycles.
- `busy` and `done` are never high simultaneously.

## Test plan
- Add, WIDTH=8, a=25, b=17, A_D=1, start one cycle → busy high 8 cycles, then done pulse; result=0x2A, cout=0, overflow=0.
- Subtract, a=10, b=20, A_D=0 → result=0xF6, cout=0 (borrow), overflow=0. Repeat with a=20, b=10 → result=0x0A, cout=1.
- Overflow/carry edges:
  - 100+100 add → result=0xC8, overflow=1, cout=0.
  - 0x80−0x01 subtract → result=0x7F, overflow=1, cout=1.
  - 0xFF+0x01 add → result=0x00, cout=1, overflow=0.
- Frozen inputs: start 3+4 add, then during RUN change a/b, toggle A_D, and pulse start → result=0x07 only. Exactly one done pulse, and no second operation begins.
- Reset mid-operation: assert reset on the 4th RUN cycle → busy=0, done never pulses, result=0, cout=0, overflow=0. A new start afterwards completes normally.
- Back-to-back: start held high with alternating operand sets → done pulses spaced exactly 10 cycles apart (WIDTH=8), each result correct.
